// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the pipeline-register files.
// Holds the stage state encoding, the NOP pattern used to build the bubble
// value, and the default payload field widths of a stage bus.
package pipe_pkg;

  // Occupancy of a stage. The single-entry build only ever uses ST_EMPTY
  // and ST_ONE (FULL); ST_TWO means both main and skid entries are live.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Instruction encoding presented by a drained or flushed stage.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Default stage payload: PC + Instr + EXT + Rs + Rt + one control bit.
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int EXT_W   = 32;
  localparam int RS_W    = 32;
  localparam int RT_W    = 32;
  localparam int CTRL_W  = 1;
  localparam int STAGE_DATA_W = PC_W + INSTR_W + EXT_W + RS_W + RT_W + CTRL_W;

  // Default width of the saturating stall counter.
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: the second (skid) entry of a pipe_stage_reg.
// Only instantiated when PIPE_STAGE_SKID_EN is defined. The owning stage
// decides when to park an entry here (load) and when to move it into the
// main entry (take); flush and reset discard whatever is held.
module pipe_skid_buf import pipe_pkg::*; #(
  parameter int DATA_W = STAGE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              take,
  input  logic [DATA_W-1:0] load_data,
  output logic              skid_valid,
  output logic [DATA_W-1:0] skid_data
);

  // Skid entry: flush wins over a same-cycle load so a killed push never lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (load) begin
      skid_valid <= 1'b1;
      skid_data  <= load_data;
    end else if (take) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// flush-to-bubble and a saturating stall counter.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry and
// make in_ready a registered signal; otherwise the stage holds one entry and
// in_ready is combinational from out_ready. Ordering, bubble and flush
// behaviour are the same in both builds.
//
// Handshake: a transfer happens at a rising edge when valid && ready on that
// side. out_valid/out_data hold steady while out_valid && !out_ready, and a
// producer may not rely on in_ready before it has driven in_valid.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int                DATA_W = STAGE_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP),
  parameter int                CNT_W  = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output state_t            state_dbg
);

  state_t state;
  logic   push;
  logic   pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign state_dbg = state;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_take;

  // Ready comes straight from the skid valid flop, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready = !skid_valid;

  // Park the incoming entry when the main entry is live and not leaving;
  // refill the main entry from the skid when the main entry leaves in TWO.
  assign skid_load = (state == ST_ONE) && push && !pop;
  assign skid_take = (state == ST_TWO) && pop;

  pipe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (skid_load),
    .take       (skid_take),
    .load_data  (in_data),
    .skid_valid (skid_valid),
    .skid_data  (skid_data)
  );

  // Occupancy FSM and main entry for the two-entry build.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state     <= ST_ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            out_data <= in_data;
          end else if (push) begin
            // New entry goes to the skid; the main entry stays put.
            state <= ST_TWO;
          end else if (pop) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= BUBBLE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            state    <= ST_ONE;
            out_data <= skid_data;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          out_data  <= BUBBLE;
        end
      endcase
    end
  end

`else

  // A single entry can take a new item whenever the current one leaves.
  assign in_ready = out_ready || !out_valid;

  // Occupancy FSM and main entry for the single-entry build (ST_ONE = FULL).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state     <= ST_ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (push) begin
            // Covers push-with-pop: the entry is replaced and stays FULL.
            out_data <= in_data;
          end else if (pop) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= BUBBLE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          out_data  <= BUBBLE;
        end
      endcase
    end
  end

`endif

  // Count downstream stall cycles, saturating; flush does not touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Works with or without PIPE_STAGE_SKID_EN; build-dependent expectations
// (in_ready timing, occupancy state) are selected from SKID.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int              DW  = 32;
  localparam logic [DW-1:0]   BUB = 32'hB0BB_1E00;
  localparam int              SDW = STAGE_DATA_W;
  localparam int              SCW = 3;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef logic [191:0] v_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main DUT: 32-bit payload, non-zero bubble
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [15:0]     stall_cnt;
  state_t          state_dbg;

  // saturation DUT: default payload, 3-bit stall counter
  logic            s_in_valid;
  logic            s_in_ready;
  logic [SDW-1:0]  s_in_data;
  logic            s_out_valid;
  logic            s_out_ready;
  logic [SDW-1:0]  s_out_data;
  logic [SCW-1:0]  s_stall_cnt;
  state_t          s_state_dbg;
  logic [SDW-1:0]  sat_pat;

  pipe_stage_reg #(
    .DATA_W (DW),
    .BUBBLE (BUB),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .state_dbg (state_dbg)
  );

  pipe_stage_reg #(
    .CNT_W (SCW)
  ) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .stall_cnt (s_stall_cnt),
    .state_dbg (s_state_dbg)
  );

  // scoreboard
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    tick();
    tick();

    // ---- during reset
    chk("rst_out_valid", v_t'(out_valid), v_t'(1'b0));
    chk("rst_out_data",  v_t'(out_data),  v_t'(BUB));
    chk("rst_in_ready",  v_t'(in_ready),  v_t'(1'b1));
    chk("rst_stall_cnt", v_t'(stall_cnt), v_t'(0));
    chk("rst_state",     v_t'(state_dbg), v_t'(ST_EMPTY));
    chk("rst_sat_data",  v_t'(s_out_data), v_t'(0));
    chk("rst_sat_ready", v_t'(s_in_ready), v_t'(1'b1));
    chk("rst_sat_state", v_t'(s_state_dbg), v_t'(ST_EMPTY));

    // ---- release, idle
    reset = 1'b1;
    tick();
    tick();
    chk("idle_out_valid", v_t'(out_valid), v_t'(1'b0));
    chk("idle_out_data",  v_t'(out_data),  v_t'(BUB));
    chk("idle_in_ready",  v_t'(in_ready),  v_t'(1'b1));
    chk("idle_stall_cnt", v_t'(stall_cnt), v_t'(0));

    // ---- streaming 1,2,3 with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h3);
    for (int i = 1; i <= 3; i++) begin
      in_data = DW'(i);
      tick();
      chk("stream_valid", v_t'(out_valid), v_t'(1'b1));
      chk("stream_data",  v_t'(out_data),  v_t'(exp_q.pop_front()));
      chk("stream_ready", v_t'(in_ready),  v_t'(1'b1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", v_t'(out_valid), v_t'(1'b0));
    chk("stream_drain_data",  v_t'(out_data),  v_t'(BUB));
    chk("stream_stall_cnt",   v_t'(stall_cnt), v_t'(0));

    // ---- back-pressure: A held, B offered during a 4-cycle stall
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    chk("bp_a_valid", v_t'(out_valid), v_t'(1'b1));
    out_ready = 1'b0; in_data = 32'hB;
    #1;
    chk("bp_ready_pre", v_t'(in_ready), v_t'(SKID ? 1'b1 : 1'b0));
    tick();
    chk("bp_ready_after1", v_t'(in_ready),  v_t'(1'b0));
    chk("bp_state",        v_t'(state_dbg), v_t'(SKID ? ST_TWO : ST_ONE));
    tick();
    tick();
    tick();
    chk("bp_held_valid", v_t'(out_valid), v_t'(1'b1));
    chk("bp_held_data",  v_t'(out_data),  v_t'(32'hA));
    chk("bp_stall_cnt",  v_t'(stall_cnt), v_t'(4));
    chk("bp_ready_held", v_t'(in_ready),  v_t'(1'b0));
    // release: the skid build already holds B, the single build takes it now
    out_ready = 1'b1;
    in_valid  = SKID ? 1'b0 : 1'b1;
    #1;
    chk("bp_release_ready", v_t'(in_ready), v_t'(SKID ? 1'b0 : 1'b1));
    chk("bp_deliver_a",     v_t'(out_data), v_t'(32'hA));
    tick();
    chk("bp_deliver_b",     v_t'(out_data),  v_t'(32'hB));
    chk("bp_b_valid",       v_t'(out_valid), v_t'(1'b1));
    chk("bp_ready_rise",    v_t'(in_ready),  v_t'(1'b1));
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", v_t'(out_valid), v_t'(1'b0));
    chk("bp_drain_data",  v_t'(out_data),  v_t'(BUB));
    chk("bp_stall_keep",  v_t'(stall_cnt), v_t'(4));

    // ---- flush with a same-cycle push
    in_valid = 1'b1; in_data = 32'h5;
    tick();
    chk("fl_hold_data", v_t'(out_data), v_t'(32'h5));
    flush = 1'b1; in_data = 32'h6;
    #1;
    chk("fl_in_ready", v_t'(in_ready), v_t'(1'b1));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", v_t'(out_valid), v_t'(1'b0));
    chk("fl_data",  v_t'(out_data),  v_t'(BUB));
    chk("fl_state", v_t'(state_dbg), v_t'(ST_EMPTY));
    tick();
    chk("fl_no6_valid", v_t'(out_valid), v_t'(1'b0));
    chk("fl_no6_data",  v_t'(out_data),  v_t'(BUB));

    // ---- flush while stalled with a second entry offered
    in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 32'h8;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fls_valid",     v_t'(out_valid), v_t'(1'b0));
    chk("fls_data",      v_t'(out_data),  v_t'(BUB));
    chk("fls_in_ready",  v_t'(in_ready),  v_t'(1'b1));
    chk("fls_stall_cnt", v_t'(stall_cnt), v_t'(6));
    chk("fls_state",     v_t'(state_dbg), v_t'(ST_EMPTY));
    out_ready = 1'b1;
    tick();
    chk("fls_no8_valid", v_t'(out_valid), v_t'(1'b0));
    chk("fls_no8_data",  v_t'(out_data),  v_t'(BUB));

    // ---- asynchronous reset mid-stall
    in_valid = 1'b1; in_data = 32'h9;
    tick();
    out_ready = 1'b0; in_data = 32'hC;
    tick();
    chk("ar_state_pre", v_t'(state_dbg), v_t'(SKID ? ST_TWO : ST_ONE));
    chk("ar_stall_pre", v_t'(stall_cnt), v_t'(7));
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid",    v_t'(out_valid), v_t'(1'b0));
    chk("ar_data",     v_t'(out_data),  v_t'(BUB));
    chk("ar_in_ready", v_t'(in_ready),  v_t'(1'b1));
    chk("ar_stall",    v_t'(stall_cnt), v_t'(0));
    chk("ar_state",    v_t'(state_dbg), v_t'(ST_EMPTY));
    #2;
    reset = 1'b1;
    tick();
    chk("ar_after_valid", v_t'(out_valid), v_t'(1'b0));
    chk("ar_after_data",  v_t'(out_data),  v_t'(BUB));
    chk("ar_after_stall", v_t'(stall_cnt), v_t'(0));
    in_valid = 1'b1; in_data = 32'hD; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ar_restart_data", v_t'(out_data), v_t'(32'hD));
    tick();
    chk("ar_restart_drain", v_t'(out_data), v_t'(BUB));

    // ---- saturation on the 3-bit counter instance
    sat_pat    = {1'b1, 32'hDEAD_BEEF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    s_in_valid = 1'b1; s_in_data = sat_pat; s_out_ready = 1'b0;
    tick();
    s_in_valid = 1'b0;
    chk("sat_valid", v_t'(s_out_valid), v_t'(1'b1));
    chk("sat_data",  v_t'(s_out_data),  v_t'(sat_pat));
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("sat_cnt", v_t'(s_stall_cnt), v_t'((i > 7) ? 7 : i));
    end
    chk("sat_data_held", v_t'(s_out_data), v_t'(sat_pat));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, flush-to-bubble, and a saturating stall counter. It is the general replacement for the fixed per-stage registers (F/D, D/E, E/M, M/W). A stage's whole payload (PC, instruction, operands, control bits) is packed into one bus. Drained or flushed entries present a configurable bubble value, normally the NOP encoding, so downstream decoders always see a legal instruction.

## Interface
Parameters:
- DATA_W, 161: payload width in bits (default is PC + Instr + EXT + Rs + Rt + 1 control bit).
- BUBBLE, 0: DATA_W-bit value presented on out_data whenever the stage holds no valid entry.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- flush  in  1  synchronous kill; discards all held entries.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  payload to the next stage.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Main entry: registers out_valid and out_data.
- Without skid (see Configuration):
  - States EMPTY and FULL.
  - in_ready = out_ready || !out_valid (combinational).
  - Push and pop in the same cycle: the main entry is replaced, and the stage stays FULL.
- With skid:
  - States EMPTY, ONE and TWO.
  - in_ready is registered and equals !skid_valid.
  - In ONE, a push without a pop parks the new entry in the skid entry and moves to TWO.
  - In TWO, a pop moves the skid entry into the main entry and moves to ONE. in_ready rises in the following cycle.
  - Ordering is strictly FIFO.
- Drain: a pop with no replacement loads BUBBLE into out_data and clears out_valid.
- Flush:
  - Clears out_valid and skid_valid, loads BUBBLE into out_data, and goes to EMPTY.
  - Flush has priority over a same-cycle push. The offered in_data is dropped even if in_ready was high.
- stall_cnt:
  - Increments by 1 each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Is unaffected by flush.
  - Clears only on reset.
- An upstream stall is expressed by holding in_valid low. A downstream stall is expressed by holding out_ready low. No separate write-enable input exists.

## Timing
- Reset values: out_valid=0, out_data=BUBBLE, stall_cnt=0, skid_valid=0, state EMPTY. in_ready reads 1 during and after reset in both configurations.
- Latency: in_data accepted at edge N appears on out_data after edge N, with out_valid=1 in cycle N+1.
- Throughput: one transfer per cycle while out_ready stays high.
- out_data and out_valid are stable while out_valid && !out_ready. This must hold in both configurations.
- If reset deasserts in the middle of an operation, the stage restarts from EMPTY. Nothing held before reset survives it.
- With skid, in_ready never depends combinationally on out_ready.

## Configuration
- PIPE_STAGE_SKID_EN defined: a 2-entry skid buffer is built and in_ready is registered. This breaks the ready path for timing closure.
- Not defined: single entry only, with in_ready combinational from out_ready. This saves DATA_W flops.
- The observable ordering, bubble and flush behaviour is identical in both builds. The only difference is the in_ready timing.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_ONE, ST_TWO);
  - the NOP constant (32'h0000_0000) used to build BUBBLE;
  - the default stage payload widths.
- Sub-module pipe_skid_buf holds the skid entry and its valid bit. It is instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset, then idle:
  - During reset: out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0.
  - After release with in_valid=0, all four stay unchanged.
- Streaming: push 0x1, 0x2, 0x3 with out_ready=1 on consecutive cycles. Required response: out_data shows 0x1, 0x2, 0x3 one cycle later each, with out_valid high for 3 cycles; out_data then returns to BUBBLE.
- Back-pressure:
  - Setup: push 0xA, then hold out_ready=0 for 4 cycles while offering 0xB.
  - Required response: out_data stays 0xA, and stall_cnt reaches 4.
  - Without skid, 0xB is never accepted during the stall. With skid, 0xB is accepted once and in_ready then drops.
  - On release, 0xA then 0xB are delivered in order.
- Flush with a same-cycle push:
  - Setup: hold 0x5 and assert flush together with in_valid and in_data=0x6.
  - Required response: out_valid=0 and out_data=BUBBLE in the next cycle, and 0x6 is never observed.
- Saturation: set CNT_W=3 and hold out_ready=0 for 10 cycles with a valid entry. Required response: stall_cnt stops at 7.
- Asynchronous reset mid-stall: assert reset between clock edges while in the TWO state. Required response: all outputs return to their reset values immediately, without waiting for a clock edge.
